// File: rtl/alu_iter_mul.sv
// alu_iter_mul: handshaked ALU.
// ADD/SUB/AND/OR/XOR complete in one cycle. Unsigned MUL is a fixed WIDTH-cycle
// shift-add sequence. A result and its flags are held until the consumer takes it.
module alu_iter_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALUControl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               zero,
  output logic               carry,
  output logic               ovf,
  output logic               err
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, r_result;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_zero, r_carry, r_ovf, r_err;

  logic                 w_accept, w_last;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [WIDTH-1:0]     w_lo;
  logic                 w_c, w_e;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign Result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;

  assign w_sum      = {1'b0, A} + {1'b0, B};
  assign w_diff     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign w_last     = (r_cnt == CNT_W'(WIDTH-1));
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle result and flags straight from the operand inputs.
  always_comb begin
    w_lo = '0;
    w_c  = 1'b0;
    w_e  = 1'b0;
    case (ALUControl)
      OP_ADD: begin w_lo = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
      OP_SUB: begin w_lo = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
      OP_AND: w_lo = A & B;
      OP_OR:  w_lo = A | B;
      OP_XOR: w_lo = A ^ B;
      OP_MUL: w_lo = '0;
      default: w_e = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: IDLE and DONE both start a new op on accept; DONE drains to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MUL: if (w_last) w_next = S_DONE;
      default: begin
        if (w_accept)
          w_next = (ALUControl == OP_MUL) ? S_MUL : S_DONE;
        else if (r_state == S_DONE && out_ready)
          w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate the multiplier, register results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_acc_next;
        r_zero   <= (w_acc_next == '0);
        r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_carry  <= 1'b0;
        r_err    <= 1'b0;
      end
    end else if (w_accept) begin
      if (ALUControl == OP_MUL) begin
        r_mcand  <= {{WIDTH{1'b0}}, A};
        r_mplier <= B;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_result <= {{WIDTH{1'b0}}, w_lo};
        r_zero   <= (w_lo == '0);
        r_carry  <= w_c;
        r_ovf    <= 1'b0;
        r_err    <= w_e;
      end
    end
  end
endmodule
